// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : input_conditioner
// Purpose  : Multi-channel push-button / switch front end. Each raw pin is
//            brought into the clock domain by a SYNC_STAGES-deep synchroniser,
//            debounced with a stability counter and turned into a clean level
//            plus single-cycle press and release pulses. With the
//            INPUT_COND_REPEAT_EN macro defined, a per-channel IDLE/DELAY/REPEAT
//            state machine also produces hold-to-repeat pulses; without it
//            repeat_pulse is tied low.
// Ports    : clock         - system clock, rising edge
//            reset         - asynchronous, active-high, clears all state
//            raw_in        - [CHANNELS] asynchronous raw pins
//            level_out     - [CHANNELS] debounced level, 1 = pressed
//            press_pulse   - [CHANNELS] one cycle on accepted press
//            release_pulse - [CHANNELS] one cycle on accepted release
//            repeat_pulse  - [CHANNELS] one cycle per auto-repeat event
// Macro    : INPUT_COND_REPEAT_EN - builds the auto-repeat logic
// Revision : 1.0 - initial release
// ============================================================================
module input_conditioner #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] repeat_pulse
);

  // Pin level meaning "not pressed"; the synchroniser resets to it so that
  // leaving reset never looks like a press.
  localparam logic C_RELEASED = (ACTIVE_LOW != 0);

  localparam int         DEB_W       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DEB_W-1:0] C_DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

`ifdef INPUT_COND_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX);
  localparam logic [RPT_W-1:0] C_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] C_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch

    // ------------------------------------------------------------------
    // Synchroniser chain
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        sync_q <= {SYNC_STAGES{C_RELEASED}};
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in[g]};
      end
    end

    logic pressed_sync;
    assign pressed_sync = sync_q[SYNC_STAGES-1] ^ C_RELEASED;

    // ------------------------------------------------------------------
    // Debounce: the counter measures how long the synchronised input has
    // disagreed with the accepted level; a single agreeing cycle restarts it.
    // ------------------------------------------------------------------
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             level_q,   level_d;
    logic             press_q,   press_d;
    logic             release_q, release_d;

    always_comb begin
      deb_cnt_d = deb_cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (pressed_sync == level_q) begin
        deb_cnt_d = '0;
      end else if (deb_cnt_q == C_DEB_LAST) begin
        level_d   = ~level_q;
        deb_cnt_d = '0;
        press_d   = ~level_q;
        release_d = level_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        deb_cnt_q <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        deb_cnt_q <= deb_cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign level_out[g]     = level_q;
    assign press_pulse[g]   = press_q;
    assign release_pulse[g] = release_q;

`ifdef INPUT_COND_REPEAT_EN
    // ------------------------------------------------------------------
    // Auto-repeat. The state machine is armed in the press_pulse cycle, so
    // the count starts the cycle after it; the pulse is decoded from the
    // registered count and level so the first repeat lands exactly
    // REPEAT_DELAY cycles after press_pulse. A dropped level suppresses the
    // pulse immediately and returns to IDLE on the next edge.
    // ------------------------------------------------------------------
    rpt_state_t       rpt_state_q, rpt_state_d;
    logic [RPT_W-1:0] rpt_cnt_q,   rpt_cnt_d;
    logic             rpt_pulse;

    always_comb begin
      rpt_state_d = rpt_state_q;
      rpt_cnt_d   = rpt_cnt_q;
      rpt_pulse   = 1'b0;
      case (rpt_state_q)
        RPT_IDLE: begin
          if (press_q) begin
            rpt_state_d = RPT_DELAY;
            rpt_cnt_d   = '0;
          end
        end
        RPT_DELAY: begin
          if (!level_q) begin
            rpt_state_d = RPT_IDLE;
            rpt_cnt_d   = '0;
          end else if (rpt_cnt_q == C_DELAY_LAST) begin
            rpt_pulse   = 1'b1;
            rpt_state_d = RPT_REPEAT;
            rpt_cnt_d   = '0;
          end else begin
            rpt_cnt_d   = rpt_cnt_q + 1'b1;
          end
        end
        RPT_REPEAT: begin
          if (!level_q) begin
            rpt_state_d = RPT_IDLE;
            rpt_cnt_d   = '0;
          end else if (rpt_cnt_q == C_PERIOD_LAST) begin
            rpt_pulse   = 1'b1;
            rpt_cnt_d   = '0;
          end else begin
            rpt_cnt_d   = rpt_cnt_q + 1'b1;
          end
        end
        default: begin
          rpt_state_d = RPT_IDLE;
          rpt_cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        rpt_state_q <= RPT_IDLE;
        rpt_cnt_q   <= '0;
      end else begin
        rpt_state_q <= rpt_state_d;
        rpt_cnt_q   <= rpt_cnt_d;
      end
    end

    assign repeat_pulse[g] = rpt_pulse;
`else
    assign repeat_pulse[g] = 1'b0;
`endif

  end : g_ch

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_conditioner
// Purpose  : Self-checking bench for input_conditioner. A behavioural model
//            (sample-delay queue, mismatch-streak debounce, press-age based
//            repeat schedule) predicts every output on every clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_conditioner;

  localparam int CH  = 2;
  localparam int S   = 2;
  localparam int DEB = 4;
  localparam int AL  = 1;
  localparam int RD  = 8;
  localparam int RP  = 3;
  localparam bit REL = (AL != 0);
  // Edges from the first sampling edge of a raw change to the visible pulse,
  // counting the sampling edge itself as edge 1.
  localparam int LAT = S + DEB;
`ifdef INPUT_COND_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] raw_in = {CH{REL}};
  logic [CH-1:0] level_out, press_pulse, release_pulse, repeat_pulse;

  int errors = 0;
  int checks = 0;

  input_conditioner #(
    .CHANNELS(CH), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DEB),
    .ACTIVE_LOW(AL), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clock(clock), .reset(reset), .raw_in(raw_in),
    .level_out(level_out), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .repeat_pulse(repeat_pulse)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  bit [CH-1:0] m_hist[$];
  bit [CH-1:0] m_lvl, m_press, m_rel, m_rpt;
  int          m_streak[CH];
  int          m_age[CH];
  bit          m_held[CH];

  function automatic void model_reset();
    m_hist.delete();
    for (int i = 0; i < S; i++) m_hist.push_back({CH{REL}});
    m_lvl = '0; m_press = '0; m_rel = '0; m_rpt = '0;
    for (int c = 0; c < CH; c++) begin
      m_streak[c] = 0; m_age[c] = 0; m_held[c] = 1'b0;
    end
  endfunction

  // One rising edge: the oldest queued sample is what the last sync stage
  // held before the edge; a new level is accepted once the pressed state has
  // disagreed with it for DEB consecutive edges.
  function automatic void model_edge(input bit [CH-1:0] raw);
    bit [CH-1:0] ps;
    ps = m_hist.pop_front() ^ {CH{REL}};
    m_hist.push_back(raw);
    m_press = '0; m_rel = '0; m_rpt = '0;
    for (int c = 0; c < CH; c++) begin
      if (ps[c] != m_lvl[c]) begin
        m_streak[c]++;
        if (m_streak[c] == DEB) begin
          m_lvl[c] = ps[c];
          m_press[c] = ps[c];
          m_rel[c] = !ps[c];
          m_streak[c] = 0;
        end
      end else begin
        m_streak[c] = 0;
      end
      if (m_press[c]) begin
        m_held[c] = 1'b1; m_age[c] = 0;
      end else if (m_lvl[c] && m_held[c]) begin
        m_age[c]++;
      end else begin
        m_held[c] = 1'b0;
      end
      m_rpt[c] = REP_EN && m_held[c] && !m_press[c] &&
                 ((m_age[c] == RD) || (m_age[c] > RD && ((m_age[c] - RD) % RP) == 0));
    end
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
    model_edge(raw_in);
  endtask

  task automatic drive(input logic [CH-1:0] v);
    @(negedge clock);
    raw_in = v;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    raw_in = 2'b11;
    reset  = 1'b1;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({level_out, press_pulse, release_pulse, repeat_pulse} !== 8'h00) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b", {level_out, press_pulse, release_pulse, repeat_pulse}, 8'h00);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({level_out, press_pulse, release_pulse, repeat_pulse} !== {m_lvl, m_press, m_rel, m_rpt}) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i,
                 {level_out, press_pulse, release_pulse, repeat_pulse}, {m_lvl, m_press, m_rel, m_rpt});
      end
    end
  endtask

  task automatic test_press_release();
    int lat;
    drive(2'b10);
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      step();
      checks++;
      if ({level_out, press_pulse, release_pulse, repeat_pulse} !== {m_lvl, m_press, m_rel, m_rpt}) begin
        errors++;
        $display("FAIL press_seq cyc=%0d got=%b exp=%b", i,
                 {level_out, press_pulse, release_pulse, repeat_pulse}, {m_lvl, m_press, m_rel, m_rpt});
      end
      if (press_pulse[0] && lat < 0) lat = i;
    end
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL press_latency got=%0d exp=%0d", lat, LAT);
    end
    drive(2'b11);
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      step();
      checks++;
      if ({level_out, press_pulse, release_pulse, repeat_pulse} !== {m_lvl, m_press, m_rel, m_rpt}) begin
        errors++;
        $display("FAIL release_seq cyc=%0d got=%b exp=%b", i,
                 {level_out, press_pulse, release_pulse, repeat_pulse}, {m_lvl, m_press, m_rel, m_rpt});
      end
      if (release_pulse[0] && lat < 0) lat = i;
    end
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL release_latency got=%0d exp=%0d", lat, LAT);
    end
  endtask

  task automatic test_bounce();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      drive(((i % 4) == 3) ? 2'b11 : 2'b10);
      step();
      checks++;
      if ({level_out, press_pulse, release_pulse, repeat_pulse} !== {m_lvl, m_press, m_rel, m_rpt}) begin
        errors++;
        $display("FAIL bounce_seq cyc=%0d got=%b exp=%b", i,
                 {level_out, press_pulse, release_pulse, repeat_pulse}, {m_lvl, m_press, m_rel, m_rpt});
      end
      if (level_out[0] || press_pulse[0] || release_pulse[0]) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL bounce_ignored got=activity exp=none");
    end
    drive(2'b11);
    repeat (6) step();
  endtask

  task automatic test_independent();
    bit both;
    drive(2'b01);              // ch1 pressed, ch0 released
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (level_out !== 2'b10) begin
      errors++;
      $display("FAIL indep_setup got=%b exp=%b", level_out, 2'b10);
    end
    drive(2'b10);              // ch0 pressed and ch1 released together
    both = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if ({level_out, press_pulse, release_pulse, repeat_pulse} !== {m_lvl, m_press, m_rel, m_rpt}) begin
        errors++;
        $display("FAIL indep_seq cyc=%0d got=%b exp=%b", i,
                 {level_out, press_pulse, release_pulse, repeat_pulse}, {m_lvl, m_press, m_rel, m_rpt});
      end
      if (press_pulse == 2'b01 && release_pulse == 2'b10 && i == LAT) both = 1'b1;
    end
    checks++;
    if (!both) begin
      errors++;
      $display("FAIL indep_same_cycle got=not_seen exp=press0_release1_at_%0d", LAT);
    end
    drive(2'b11);
    repeat (8) step();
  endtask

  task automatic test_repeat();
    int press_at, first_rpt, after_rel;
    drive(2'b10);
    press_at = -1; first_rpt = -1; after_rel = 0;
    for (int i = 1; i <= 26; i++) begin
      step();
      checks++;
      if ({level_out, press_pulse, release_pulse, repeat_pulse} !== {m_lvl, m_press, m_rel, m_rpt}) begin
        errors++;
        $display("FAIL repeat_hold cyc=%0d got=%b exp=%b", i,
                 {level_out, press_pulse, release_pulse, repeat_pulse}, {m_lvl, m_press, m_rel, m_rpt});
      end
      if (press_pulse[0] && press_at < 0) press_at = i;
      if (repeat_pulse[0] && first_rpt < 0) first_rpt = i;
    end
    checks++;
    if (REP_EN ? (first_rpt - press_at != RD) : (first_rpt != -1)) begin
      errors++;
      $display("FAIL repeat_first got=%0d exp=%0d", first_rpt - press_at, REP_EN ? RD : -1);
    end
    drive(2'b11);
    for (int i = 1; i <= 16; i++) begin
      step();
      checks++;
      if ({level_out, press_pulse, release_pulse, repeat_pulse} !== {m_lvl, m_press, m_rel, m_rpt}) begin
        errors++;
        $display("FAIL repeat_release cyc=%0d got=%b exp=%b", i,
                 {level_out, press_pulse, release_pulse, repeat_pulse}, {m_lvl, m_press, m_rel, m_rpt});
      end
      if (!level_out[0] && repeat_pulse[0]) after_rel++;
    end
    checks++;
    if (after_rel != 0) begin
      errors++;
      $display("FAIL repeat_after_release got=%0d exp=0", after_rel);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    drive(2'b10);
    repeat (4) step();         // debounce count now at 2
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({level_out, press_pulse, release_pulse, repeat_pulse} !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_clear got=%b exp=%b", {level_out, press_pulse, release_pulse, repeat_pulse}, 8'h00);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;              // key still held
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if ({level_out, press_pulse, release_pulse, repeat_pulse} !== {m_lvl, m_press, m_rel, m_rpt}) begin
        errors++;
        $display("FAIL reset_mid_seq cyc=%0d got=%b exp=%b", i,
                 {level_out, press_pulse, release_pulse, repeat_pulse}, {m_lvl, m_press, m_rel, m_rpt});
      end
      if (press_pulse[0] && lat < 0) lat = i;
    end
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL reset_mid_latency got=%0d exp=%0d", lat, LAT);
    end
    drive(2'b11);
    repeat (8) step();
  endtask

  task automatic test_random();
    logic [CH-1:0] v;
    v = 2'b11;
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 9) == 0) v[c] = ~v[c];
      drive(v);
      step();
      checks++;
      if ({level_out, press_pulse, release_pulse, repeat_pulse} !== {m_lvl, m_press, m_rel, m_rpt}) begin
        errors++;
        $display("FAIL random_seq cyc=%0d raw=%b got=%b exp=%b", i, v,
                 {level_out, press_pulse, release_pulse, repeat_pulse}, {m_lvl, m_press, m_rel, m_rpt});
      end
    end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_bounce();
    test_independent();
    test_repeat();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
